// File: rtl/matmul_sequencer.sv
// Sequencer for one N x N by N x N matrix multiply on a shared datapath:
// walks i, j, k row-major, issuing A/B reads, MAC enables and C writes.
module matmul_sequencer #(
    parameter int N      = 2,
    parameter int ADDR_W = 8
) (
    input  logic              fast_clock,
    input  logic              reset_n,
    input  logic              start_process,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              mac_clear,
    output logic              mac_en,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);
    localparam int                CW   = $clog2(N);
    localparam logic [CW-1:0]     LAST = CW'(N - 1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state;
    logic [CW-1:0]     i;
    logic [CW-1:0]     j;
    logic [CW-1:0]     k;
    logic [ADDR_W-1:0] a_base;

    assign state_dbg = state;

    // start_process is a level request consumed only in IDLE; rd_en, mac_en and
    // c_we are single-cycle strobes, the datapath never back-pressures them.
    always_ff @(posedge fast_clock) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            a_base    <= '0;
            rd_en     <= 1'b0;
            a_addr    <= '0;
            b_addr    <= '0;
            mac_clear <= 1'b0;
            mac_en    <= 1'b0;
            c_we      <= 1'b0;
            c_addr    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mac_en    <= rd_en;
            rd_en     <= 1'b0;
            mac_clear <= 1'b0;
            c_we      <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_process) begin
                        state     <= S_CLEAR;
                        mac_clear <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state  <= S_ISSUE;
                    rd_en  <= 1'b1;
                    k      <= '0;
                    a_addr <= a_base;
                    b_addr <= ADDR_W'(j);
                end
                S_ISSUE: begin
                    if (k == LAST) begin
                        state  <= S_WAIT;
                        a_addr <= '0;
                        b_addr <= '0;
                    end else begin
                        rd_en  <= 1'b1;
                        k      <= k + CW'(1);
                        a_addr <= a_addr + ADDR_W'(1);
                        b_addr <= b_addr + STEP;
                    end
                end
                S_WAIT: begin
                    // The last operand pair lands in the MAC during this cycle.
                    state  <= S_WRITE;
                    c_we   <= 1'b1;
                    c_addr <= a_base + ADDR_W'(j);
                    k      <= '0;
                end
                S_WRITE: begin
                    c_addr <= '0;
                    if (i == LAST && j == LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= S_CLEAR;
                        mac_clear <= 1'b1;
                        if (j == LAST) begin
                            j      <= '0;
                            i      <= i + CW'(1);
                            a_base <= a_base + STEP;
                        end else begin
                            j <= j + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    i      <= '0;
                    j      <= '0;
                    a_base <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: N=2 and N=3 instances, behavioural A/B memories
// and MAC, scoreboard queues for reads and C writes, directed timing steps.
module tb_matmul_sequencer;
    logic fast_clock = 1'b0;
    always #5 fast_clock = ~fast_clock;

    int cyc = 0;
    always @(posedge fast_clock) cyc <= cyc + 1;

    logic       reset_n, start2, start3;
    logic       rd_en2, mac_clear2, mac_en2, c_we2, busy2, done2;
    logic [7:0] a_addr2, b_addr2, c_addr2;
    logic [2:0] state2;
    logic       rd_en3, mac_clear3, mac_en3, c_we3, busy3, done3;
    logic [7:0] a_addr3, b_addr3, c_addr3;
    logic [2:0] state3;

    matmul_sequencer #(.N(2), .ADDR_W(8)) dut2 (
        .fast_clock(fast_clock), .reset_n(reset_n), .start_process(start2),
        .rd_en(rd_en2), .a_addr(a_addr2), .b_addr(b_addr2),
        .mac_clear(mac_clear2), .mac_en(mac_en2), .c_we(c_we2), .c_addr(c_addr2),
        .busy(busy2), .done(done2), .state_dbg(state2)
    );

    matmul_sequencer #(.N(3), .ADDR_W(8)) dut3 (
        .fast_clock(fast_clock), .reset_n(reset_n), .start_process(start3),
        .rd_en(rd_en3), .a_addr(a_addr3), .b_addr(b_addr3),
        .mac_clear(mac_clear3), .mac_en(mac_en3), .c_we(c_we3), .c_addr(c_addr3),
        .busy(busy3), .done(done3), .state_dbg(state3)
    );

    logic [29:0] out2, out3;
    assign out2 = {rd_en2, a_addr2, b_addr2, mac_clear2, mac_en2, c_we2, c_addr2, busy2, done2};
    assign out3 = {rd_en3, a_addr3, b_addr3, mac_clear3, mac_en3, c_we3, c_addr3, busy3, done3};

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Memories and MAC: 1-cycle read latency, accumulate on mac_en
    logic [15:0] a2_mem [256];
    logic [15:0] b2_mem [256];
    logic [15:0] a3_mem [256];
    logic [15:0] b3_mem [256];
    logic [15:0] a_d2, b_d2, acc2, a_d3, b_d3, acc3;

    always @(posedge fast_clock) begin
        if (rd_en2) begin
            a_d2 <= a2_mem[a_addr2];
            b_d2 <= b2_mem[b_addr2];
        end
        if (mac_clear2) acc2 <= '0;
        else if (mac_en2) acc2 <= acc2 + a_d2 * b_d2;
        if (rd_en3) begin
            a_d3 <= a3_mem[a_addr3];
            b_d3 <= b3_mem[b_addr3];
        end
        if (mac_clear3) acc3 <= '0;
        else if (mac_en3) acc3 <= acc3 + a_d3 * b_d3;
    end

    // Scoreboard queues
    logic [15:0] exp_rd2 [$];
    logic [23:0] exp_c2 [$];
    logic [23:0] exp_c3 [$];

    logic [15:0] rd_tab2 [8] = '{16'h0000, 16'h0102, 16'h0001, 16'h0103,
                                 16'h0200, 16'h0302, 16'h0201, 16'h0303};
    logic [15:0] c_tab2 [4] = '{16'd19, 16'd22, 16'd43, 16'd50};
    logic [15:0] c_tab3 [9] = '{16'd13, 16'd17, 16'd21, 16'd16, 16'd20, 16'd24,
                                16'd19, 16'd23, 16'd27};

    int c_we2_cnt = 0, mac2_cnt = 0, done2_cnt = 0, done2_cyc = -1;
    int c_we3_cnt = 0, mac3_cnt = 0, done3_cnt = 0, done3_cyc = -1;

    always @(negedge fast_clock) begin
        logic [23:0] e;
        logic [15:0] r;
        check("inv2_clear_mac", 32'(mac_clear2 & mac_en2), 32'd0);
        check("inv2_cwe_rd_mac", 32'(c_we2 & (rd_en2 | mac_en2)), 32'd0);
        if (mac_en2 === 1'b1) mac2_cnt++;
        if (done2 === 1'b1) begin
            done2_cnt++;
            done2_cyc = cyc;
        end
        if (rd_en2 === 1'b1) begin
            check("rd2_pending", 32'(exp_rd2.size() != 0), 32'd1);
            if (exp_rd2.size() != 0) begin
                r = exp_rd2.pop_front();
                check("rd2_addr", 32'({a_addr2, b_addr2}), 32'(r));
            end
        end
        if (c_we2 === 1'b1) begin
            c_we2_cnt++;
            check("c2_pending", 32'(exp_c2.size() != 0), 32'd1);
            if (exp_c2.size() != 0) begin
                e = exp_c2.pop_front();
                check("c2_write", 32'({c_addr2, acc2}), 32'(e));
            end
        end
    end

    always @(negedge fast_clock) begin
        logic [23:0] e;
        check("inv3_clear_mac", 32'(mac_clear3 & mac_en3), 32'd0);
        check("inv3_cwe_rd_mac", 32'(c_we3 & (rd_en3 | mac_en3)), 32'd0);
        if (mac_en3 === 1'b1) mac3_cnt++;
        if (done3 === 1'b1) begin
            done3_cnt++;
            done3_cyc = cyc;
        end
        if (c_we3 === 1'b1) begin
            c_we3_cnt++;
            check("c3_pending", 32'(exp_c3.size() != 0), 32'd1);
            if (exp_c3.size() != 0) begin
                e = exp_c3.pop_front();
                check("c3_write", 32'({c_addr3, acc3}), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge fast_clock);
        #1;
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic push_n2();
        for (int n = 0; n < 8; n++) exp_rd2.push_back(rd_tab2[n]);
        for (int n = 0; n < 4; n++) exp_c2.push_back({8'(n), c_tab2[n]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, b_cwe, b_mac, b_done;
        foreach (a2_mem[n]) begin
            a2_mem[n] = '0; b2_mem[n] = '0; a3_mem[n] = '0; b3_mem[n] = '0;
        end
        for (int n = 0; n < 4; n++) begin
            a2_mem[n] = 16'(n + 1);
            b2_mem[n] = 16'(n + 5);
        end
        for (int n = 0; n < 9; n++) begin
            a3_mem[n] = (n % 4 == 0) ? 16'd2 : 16'd1;
            b3_mem[n] = 16'(n + 1);
        end

        // Reset held 3 cycles with start high
        reset_n = 1'b0;
        start2  = 1'b1;
        start3  = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("rst_out2", 32'(out2), 32'd0);
            check("rst_out3", 32'(out3), 32'd0);
            check("rst_state2", 32'(state2), 32'd0);
            check("rst_state3", 32'(state3), 32'd0);
        end
        start2  = 1'b0;
        start3  = 1'b0;
        reset_n = 1'b1;
        tick();
        check("post_rst_idle2", 32'(out2), 32'd0);

        // Full N=2 run
        b_cwe = c_we2_cnt; b_mac = mac2_cnt; b_done = done2_cnt; done2_cyc = -1;
        push_n2();
        start2 = 1'b1;
        t0 = cyc;
        tick();
        start2 = 1'b0;
        check("t2_clear_state", 32'(state2), 32'd1);
        check("t2_clear_pulse", 32'(mac_clear2), 32'd1);
        check("t2_busy", 32'(busy2), 32'd1);
        tick_to(t0 + 30);
        check("t2_done_cyc", 32'(done2_cyc - t0), 32'd21);
        check("t2_done_cnt", 32'(done2_cnt - b_done), 32'd1);
        check("t2_cwe_cnt", 32'(c_we2_cnt - b_cwe), 32'd4);
        check("t2_mac_cnt", 32'(mac2_cnt - b_mac), 32'd8);
        check("t2_c_left", 32'(exp_c2.size()), 32'd0);
        check("t2_rd_left", 32'(exp_rd2.size()), 32'd0);
        check("t2_idle_out", 32'(out2), 32'd0);

        // Start pulsed again while busy
        b_cwe = c_we2_cnt; b_done = done2_cnt; done2_cyc = -1;
        push_n2();
        start2 = 1'b1;
        t0 = cyc;
        tick();
        start2 = 1'b0;
        tick_to(t0 + 7);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick_to(t0 + 60);
        check("t3_done_cyc", 32'(done2_cyc - t0), 32'd21);
        check("t3_done_cnt", 32'(done2_cnt - b_done), 32'd1);
        check("t3_cwe_cnt", 32'(c_we2_cnt - b_cwe), 32'd4);
        check("t3_c_left", 32'(exp_c2.size()), 32'd0);
        check("t3_state", 32'(state2), 32'd0);

        // Reset mid-run, then restart
        b_done = done2_cnt; done2_cyc = -1;
        push_n2();
        start2 = 1'b1;
        t0 = cyc;
        tick();
        start2 = 1'b0;
        tick_to(t0 + 9);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t4_rst_out", 32'(out2), 32'd0);
        check("t4_rst_state", 32'(state2), 32'd0);
        tick();
        check("t4_rst_out_b", 32'(out2), 32'd0);
        check("t4_c_pending", 32'(exp_c2.size()), 32'd3);
        check("t4_rd_pending", 32'(exp_rd2.size()), 32'd4);
        check("t4_no_done", 32'(done2_cnt - b_done), 32'd0);
        exp_c2.delete();
        exp_rd2.delete();
        tick_to(t0 + 12);
        b_cwe = c_we2_cnt;
        push_n2();
        start2 = 1'b1;
        t1 = cyc;
        tick();
        start2 = 1'b0;
        tick_to(t1 + 30);
        check("t4_restart_t0", 32'(t1 - t0), 32'd12);
        check("t4_done_cyc", 32'(done2_cyc - t1), 32'd21);
        check("t4_done_cnt", 32'(done2_cnt - b_done), 32'd1);
        check("t4_cwe_cnt", 32'(c_we2_cnt - b_cwe), 32'd4);
        check("t4_c_left", 32'(exp_c2.size()), 32'd0);

        // Back-to-back with start held high
        b_done = done2_cnt; b_cwe = c_we2_cnt; done2_cyc = -1;
        push_n2();
        push_n2();
        start2 = 1'b1;
        t0 = cyc;
        tick();
        tick_to(t0 + 22);
        check("t5_first_done", 32'(done2_cyc - t0), 32'd21);
        check("t5_gap_state", 32'(state2), 32'd0);
        check("t5_gap_busy", 32'(busy2), 32'd0);
        tick();
        check("t5_clear_state", 32'(state2), 32'd1);
        check("t5_clear_pulse", 32'(mac_clear2), 32'd1);
        start2 = 1'b0;
        tick_to(t0 + 55);
        check("t5_second_done", 32'(done2_cyc - t0), 32'd43);
        check("t5_done_cnt", 32'(done2_cnt - b_done), 32'd2);
        check("t5_cwe_cnt", 32'(c_we2_cnt - b_cwe), 32'd8);
        check("t5_c_left", 32'(exp_c2.size()), 32'd0);

        // N=3 run
        b_cwe = c_we3_cnt; b_mac = mac3_cnt; b_done = done3_cnt; done3_cyc = -1;
        for (int n = 0; n < 9; n++) exp_c3.push_back({8'(n), c_tab3[n]});
        start3 = 1'b1;
        t0 = cyc;
        tick();
        start3 = 1'b0;
        tick_to(t0 + 65);
        check("t6_done_cyc", 32'(done3_cyc - t0), 32'd55);
        check("t6_done_cnt", 32'(done3_cnt - b_done), 32'd1);
        check("t6_cwe_cnt", 32'(c_we3_cnt - b_cwe), 32'd9);
        check("t6_mac_cnt", 32'(mac3_cnt - b_mac), 32'd27);
        check("t6_c_left", 32'(exp_c3.size()), 32'd0);
        check("t6_idle_out", 32'(out3), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Control unit that sequences one N×N by N×N matrix multiplication on the processor's shared datapath: single-port A/B operand memories (1-cycle read latency), one multiply-accumulate (MAC) unit and a C result memory. On `start_process` it walks i, j, k in row-major order. For each operand pair it issues read addresses, enables the MAC when the data returns, and writes each finished dot product to C. It sits between the top-level `start_process` control and the memory/MAC datapath inside `top_processor`.

## Interface
- `N`, 2: matrix dimension. Legal range is 2..15.
- `ADDR_W`, 8: address width for A, B and C. Must be ≥ ceil(log2(N·N)).
- `fast_clock`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `start_process`  in  1  level request to start a multiply; sampled only in IDLE.
- `rd_en`  out  1  read strobe to the A and B memories.
- `a_addr`  out  ADDR_W  A read address, i·N+k.
- `b_addr`  out  ADDR_W  B read address, k·N+j.
- `mac_clear`  out  1  zeroes the MAC accumulator.
- `mac_en`  out  1  accumulates A·B data presented this cycle.
- `c_we`  out  1  write strobe to the C memory.
- `c_addr`  out  ADDR_W  C write address, i·N+j.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Outputs are decoded from registered state and counters only. There is no combinational path from any input to any output.
- Counters are `i`, `j` and `k`, each 0..N-1. Addresses come from incremental bases (a_base += N per row, b_addr += N per k), not from a multiplier.
- **IDLE:** all outputs are 0, including all address outputs. Goes to CLEAR if `start_process`=1.
- **CLEAR (1 cycle):** `mac_clear`=1. Sets k=0. Goes to ISSUE.
- **ISSUE (N cycles):**
  - `rd_en`=1, `a_addr`=i·N+k, `b_addr`=k·N+j.
  - k increments each cycle.
  - Goes to WAIT after the cycle with k=N-1.
- **WAIT (1 cycle):** drains the last read. `rd_en`=0.
- `mac_en` equals `rd_en` delayed one cycle. It is high on ISSUE cycles 2..N and on the WAIT cycle: exactly N pulses per element.
- **WRITE (1 cycle):** `c_we`=1, `c_addr`=i·N+j. Then:
  - If (i,j)=(N-1,N-1), go to DONE.
  - Otherwise j increments; on a j wrap, i increments. Go to CLEAR.
- **DONE (1 cycle):** `done`=1, `busy`=1. Goes to IDLE unconditionally.
- `start_process` is ignored in every state except IDLE. Holding it high through DONE starts a new run after one IDLE cycle.
- Counter widths are ceil(log2(N)) bits. Address arithmetic is in ADDR_W bits, and the legal range guarantees no overflow.

## Timing
- **Reset:** `reset_n`=0 at a rising edge forces IDLE and zeroes all counters and the `mac_en` delay register. All outputs are 0 from the following cycle.
  - This applies mid-run as well. Any partial C contents are abandoned, and there is no `done` pulse.
  - Reset has priority over `start_process`.
- **Start:** `start_process` sampled high in IDLE at edge T0 puts the block in CLEAR during cycle T0+1.
- **Per-element cost:** N+3 cycles (CLEAR + N×ISSUE + WAIT + WRITE).
- **Completion:** `done` is high during cycle T0+1+N²·(N+3). For N=2 that is T0+21; for N=3 it is T0+55.
- `c_we` fires exactly N² times per run, with `c_addr` taking 0,1,…,N²-1 in order.
- `mac_clear` and `mac_en` are never high in the same cycle. `c_we` is never high together with `rd_en` or `mac_en`.

## Test plan
1. **Reset values:** hold `reset_n`=0 for 3 cycles with `start_process`=1 -> every output stays 0 and the block remains in IDLE.
2. **Full N=2 run:** pulse `start_process` for 1 cycle -> required sequence:
   - element 0: `mac_clear`; then `a_addr`/`b_addr` = 0/0, 1/2; then WAIT; then `c_we` with `c_addr`=0.
   - elements 1..3: `a_addr`/`b_addr` = 0/1,1/3; 2/0,3/2; 2/1,3/3.
   - `c_addr` sequence = 0,1,2,3.
   - `done` at T0+21.
   - The bench behaviourally models the memories/MAC with A=[1 2;3 4], B=[5 6;7 8] and checks C=[19 22;43 50].
3. **Start while busy:** pulse `start_process` again at T0+7 -> no effect: still exactly 4 `c_we` pulses and one `done` at T0+21.
4. **Reset mid-run:** `reset_n`=0 at T0+9 -> outputs are 0 from T0+10. `start_process` at T0+12 restarts from i=j=k=0, and `done` arrives 21 cycles later.
5. **Back-to-back:** hold `start_process`=1 continuously -> `done` at T0+21, then IDLE for 1 cycle, then CLEAR at T0+23, with a second `done` at T0+43.
6. **N=3 parameterisation:** a 1-cycle start -> 9 `c_we` pulses, 27 `mac_en` pulses and `done` at T0+55. Checked against a reference 3×3 product with A = identity + 1 and B = 1..9.
